// File: rtl/wb_write_arbiter_if.sv
// Bundle between the writeback sources, the arbiter and the reg_file write port.
// 'master' is the source/environment side, 'slave' is the arbiter side.
interface wb_write_arbiter_if #(
  parameter int unsigned SIZE       = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned ADDR_W = $clog2(NUM_REGS);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  logic              p_valid;
  logic [ADDR_W-1:0] p_addr;
  logic [SIZE-1:0]   p_data;
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [SIZE-1:0]   a_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [SIZE-1:0]   wr_data;
  logic [NUM_REGS-1:0] pending;
  logic              stall_req;
  logic [CNT_W-1:0]  fifo_count;
  logic              proto_err;

  modport master (
    output p_valid, p_addr, p_data, a_valid, a_addr, a_data,
    input  a_ready, wr_en, wr_addr, wr_data, pending, stall_req, fifo_count, proto_err
  );

  modport slave (
    input  p_valid, p_addr, p_data, a_valid, a_addr, a_data,
    output a_ready, wr_en, wr_addr, wr_data, pending, stall_req, fifo_count, proto_err
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Merges the pipeline writeback and a FIFO-buffered long-latency source onto one
// reg_file write port, with a pending-write scoreboard and starvation stall.
module wb_write_arbiter #(
  parameter int unsigned SIZE       = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input logic              i_clk,
  input logic              i_rst_n,
  wb_write_arbiter_if.slave bus
);
  localparam int unsigned ADDR_W = $clog2(NUM_REGS);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ST_W   = $clog2(STARVE_MAX + 1);

  logic [ADDR_W-1:0]   r_fifo_addr [FIFO_DEPTH];
  logic [SIZE-1:0]     r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_W-1:0]    r_count;
  logic [ST_W-1:0]     r_starve;
  logic                r_stall;
  logic                r_proto_err;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [SIZE-1:0]     r_wr_data;

  logic                w_a_ready;
  logic                w_push;
  logic                w_pop;
  logic                w_issue_p;
  logic                w_fifo_ne;
  logic                w_p_req;
  logic [NUM_REGS-1:0] w_pending;

  assign w_a_ready = (r_count < CNT_W'(FIFO_DEPTH));
  assign w_fifo_ne = (r_count != '0);
  assign w_p_req   = bus.p_valid && (bus.p_addr != '0);
  // Writes to r0 complete the handshake but are dropped here.
  assign w_push    = bus.a_valid && w_a_ready && (bus.a_addr != '0);

  always_comb begin
    w_issue_p = 1'b0;
    w_pop     = 1'b0;
    if (r_stall) begin
      w_pop = w_fifo_ne;
    end else if (w_p_req) begin
      w_issue_p = 1'b1;
    end else begin
      w_pop = w_fifo_ne;
    end
  end

  always_comb begin
    w_pending = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (i < 32'(r_count)) begin
        w_pending[r_fifo_addr[r_rptr + PTR_W'(i)]] = 1'b1;
      end
    end
    if (r_wr_en) w_pending[r_wr_addr] = 1'b1;
    w_pending[0] = 1'b0;
  end

  // Storage needs no reset: validity is tracked by the pointers and count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= bus.a_addr;
      r_fifo_data[r_wptr] <= bus.a_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_starve    <= '0;
      r_stall     <= 1'b0;
      r_proto_err <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      if (w_issue_p) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= bus.p_addr;
        r_wr_data <= bus.p_data;
      end else if (w_pop) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_fifo_addr[r_rptr];
        r_wr_data <= r_fifo_data[r_rptr];
      end else begin
        r_wr_en   <= 1'b0;
      end

      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);

      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      // Saturating count of cycles the FIFO head lost to the pipeline.
      if (w_pop || !w_fifo_ne) begin
        r_starve <= '0;
      end else if (w_issue_p && (r_starve != ST_W'(STARVE_MAX))) begin
        r_starve <= r_starve + ST_W'(1);
      end

      if (r_starve == ST_W'(STARVE_MAX)) begin
        r_stall <= 1'b1;
      end else if (r_stall && !w_fifo_ne) begin
        r_stall <= 1'b0;
      end

      if (bus.p_valid && r_stall) r_proto_err <= 1'b1;
    end
  end

  assign bus.a_ready    = w_a_ready;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.pending    = w_pending;
  assign bus.stall_req  = r_stall;
  assign bus.fifo_count = r_count;
  assign bus.proto_err  = r_proto_err;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed vector bench for wb_write_arbiter: a table of single-cycle vectors
// plus hand-written starvation and mid-drain reset sequences.
module tb_wb_write_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  wb_write_arbiter_if #(.SIZE(32), .NUM_REGS(32), .FIFO_DEPTH(4)) bus ();

  wb_write_arbiter #(
    .SIZE(32), .NUM_REGS(32), .FIFO_DEPTH(4), .STARVE_MAX(8)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        p_valid;
    logic [4:0]  p_addr;
    logic [31:0] p_data;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        e_wr_en;
    logic [4:0]  e_wr_addr;
    logic [31:0] e_wr_data;
    logic [2:0]  e_count;
    logic        e_ready;
    logic [31:0] e_pending;
  } vec_t;

  vec_t vecs[19];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad);
    bus.p_valid = pv;
    bus.p_addr  = pa;
    bus.p_data  = pd;
    bus.a_valid = av;
    bus.a_addr  = aa;
    bus.a_data  = ad;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    //        pv pa    pdata        av aa    adata       en addr  wdata        cnt rdy pending
    vecs[0]  = '{1, 5'd3,  32'h77,  0, 5'd0,  32'h0,     1, 5'd3,  32'h77,  3'd0, 1, 32'h0000_0008};
    vecs[1]  = '{0, 5'd0,  32'h0,   0, 5'd0,  32'h0,     0, 5'd3,  32'h77,  3'd0, 1, 32'h0};
    vecs[2]  = '{1, 5'd10, 32'h100, 1, 5'd5,  32'hA0,    1, 5'd10, 32'h100, 3'd1, 1, 32'h0000_0420};
    vecs[3]  = '{1, 5'd11, 32'h101, 1, 5'd6,  32'hA1,    1, 5'd11, 32'h101, 3'd2, 1, 32'h0000_0860};
    vecs[4]  = '{1, 5'd12, 32'h102, 1, 5'd7,  32'hA2,    1, 5'd12, 32'h102, 3'd3, 1, 32'h0000_10E0};
    vecs[5]  = '{1, 5'd13, 32'h103, 1, 5'd8,  32'hA3,    1, 5'd13, 32'h103, 3'd4, 0, 32'h0000_21E0};
    vecs[6]  = '{0, 5'd0,  32'h0,   1, 5'd9,  32'hEE,    1, 5'd5,  32'hA0,  3'd3, 1, 32'h0000_01E0};
    vecs[7]  = '{0, 5'd0,  32'h0,   0, 5'd0,  32'h0,     1, 5'd6,  32'hA1,  3'd2, 1, 32'h0000_01C0};
    vecs[8]  = '{0, 5'd0,  32'h0,   0, 5'd0,  32'h0,     1, 5'd7,  32'hA2,  3'd1, 1, 32'h0000_0180};
    vecs[9]  = '{0, 5'd0,  32'h0,   0, 5'd0,  32'h0,     1, 5'd8,  32'hA3,  3'd0, 1, 32'h0000_0100};
    vecs[10] = '{0, 5'd0,  32'h0,   0, 5'd0,  32'h0,     0, 5'd8,  32'hA3,  3'd0, 1, 32'h0};
    vecs[11] = '{1, 5'd0,  32'hFF,  1, 5'd0,  32'hFF,    0, 5'd8,  32'hA3,  3'd0, 1, 32'h0};
    vecs[12] = '{0, 5'd0,  32'h0,   0, 5'd0,  32'h0,     0, 5'd8,  32'hA3,  3'd0, 1, 32'h0};
    vecs[13] = '{1, 5'd14, 32'h200, 1, 5'd20, 32'hB0,    1, 5'd14, 32'h200, 3'd1, 1, 32'h0010_4000};
    vecs[14] = '{1, 5'd15, 32'h201, 1, 5'd21, 32'hB1,    1, 5'd15, 32'h201, 3'd2, 1, 32'h0030_8000};
    vecs[15] = '{0, 5'd0,  32'h0,   1, 5'd22, 32'hB2,    1, 5'd20, 32'hB0,  3'd2, 1, 32'h0070_0000};
    vecs[16] = '{0, 5'd0,  32'h0,   0, 5'd0,  32'h0,     1, 5'd21, 32'hB1,  3'd1, 1, 32'h0060_0000};
    vecs[17] = '{0, 5'd0,  32'h0,   0, 5'd0,  32'h0,     1, 5'd22, 32'hB2,  3'd0, 1, 32'h0040_0000};
    vecs[18] = '{0, 5'd0,  32'h0,   0, 5'd0,  32'h0,     0, 5'd22, 32'hB2,  3'd0, 1, 32'h0};

    #3;
    chk("reset wr_en", 64'(bus.wr_en), 64'd0);
    chk("reset wr_addr", 64'(bus.wr_addr), 64'd0);
    chk("reset wr_data", 64'(bus.wr_data), 64'd0);
    chk("reset fifo_count", 64'(bus.fifo_count), 64'd0);
    chk("reset pending", 64'(bus.pending), 64'd0);
    chk("reset stall_req", 64'(bus.stall_req), 64'd0);
    chk("reset proto_err", 64'(bus.proto_err), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("release a_ready", 64'(bus.a_ready), 64'd1);

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].p_valid, vecs[i].p_addr, vecs[i].p_data,
            vecs[i].a_valid, vecs[i].a_addr, vecs[i].a_data);
      tick();
      chk($sformatf("v%0d wr_en", i), 64'(bus.wr_en), 64'(vecs[i].e_wr_en));
      chk($sformatf("v%0d wr_addr", i), 64'(bus.wr_addr), 64'(vecs[i].e_wr_addr));
      chk($sformatf("v%0d wr_data", i), 64'(bus.wr_data), 64'(vecs[i].e_wr_data));
      chk($sformatf("v%0d fifo_count", i), 64'(bus.fifo_count), 64'(vecs[i].e_count));
      chk($sformatf("v%0d a_ready", i), 64'(bus.a_ready), 64'(vecs[i].e_ready));
      chk($sformatf("v%0d pending", i), 64'(bus.pending), 64'(vecs[i].e_pending));
      chk($sformatf("v%0d stall_req", i), 64'(bus.stall_req), 64'd0);
      chk($sformatf("v%0d proto_err", i), 64'(bus.proto_err), 64'd0);
    end

    // Starvation: reg 9 buffered while the pipeline wins every cycle.
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h99);
    tick();
    chk("starve push count", 64'(bus.fifo_count), 64'd1);
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, 5'(16 + k), 32'(k), 1'b0, 5'd0, 32'h0);
      tick();
      chk($sformatf("starve%0d wr_addr", k), 64'(bus.wr_addr), 64'(16 + k));
      chk($sformatf("starve%0d stall_req", k), 64'(bus.stall_req), 64'(k == 8));
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("drain wr_en", 64'(bus.wr_en), 64'd1);
    chk("drain wr_addr", 64'(bus.wr_addr), 64'd9);
    chk("drain wr_data", 64'(bus.wr_data), 64'h99);
    chk("drain count", 64'(bus.fifo_count), 64'd0);
    chk("drain stall held", 64'(bus.stall_req), 64'd1);
    chk("drain pending", 64'(bus.pending), 64'h200);
    drive(1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 32'h0);
    tick();
    chk("stall clear", 64'(bus.stall_req), 64'd0);
    chk("ignored p wr_en", 64'(bus.wr_en), 64'd0);
    chk("proto_err set", 64'(bus.proto_err), 64'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("proto_err sticky", 64'(bus.proto_err), 64'd1);
    chk("idle wr_addr hold", 64'(bus.wr_addr), 64'd9);

    // Reset asserted while the FIFO is draining.
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd24, 32'hC0);
    tick();
    drive(1'b1, 5'd2, 32'h12, 1'b1, 5'd25, 32'hC1);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("pre-reset wr_addr", 64'(bus.wr_addr), 64'd24);
    chk("pre-reset count", 64'(bus.fifo_count), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst wr_en", 64'(bus.wr_en), 64'd0);
    chk("async rst count", 64'(bus.fifo_count), 64'd0);
    chk("async rst pending", 64'(bus.pending), 64'd0);
    chk("async rst proto_err", 64'(bus.proto_err), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post-rst wr_en", 64'(bus.wr_en), 64'd0);
    chk("post-rst wr_addr", 64'(bus.wr_addr), 64'd0);
    tick();
    chk("post-rst wr_en 2", 64'(bus.wr_en), 64'd0);
    chk("post-rst count", 64'(bus.fifo_count), 64'd0);
    chk("post-rst a_ready", 64'(bus.a_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
